// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and default constants for the interrupt controller
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVICE,
        ACK
    } intc_state_e;

    localparam int INTC_NUM_IRQ        = 8;
    localparam int INTC_SERVICE_CYCLES = 4;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - masked fixed-priority encoder, index 0 wins
module intc_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] requests,
    input  logic [NUM_IRQ-1:0] mask,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [NUM_IRQ-1:0] eligible;

    assign eligible = requests & ~mask;

    // Scan from the top down so the lowest eligible index is the last to write id
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority interrupt controller with auto-ack; INTC_ACK_PORT_EN adds irq_ack/irq_ack_id
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_IRQ        = INTC_NUM_IRQ,
    parameter int ID_W           = $clog2(NUM_IRQ),
    parameter int SERVICE_CYCLES = INTC_SERVICE_CYCLES
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_requests,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id
`ifdef INTC_ACK_PORT_EN
    ,
    output logic               irq_ack,
    output logic [ID_W-1:0]    irq_ack_id
`endif
);

    localparam int              CNT_W    = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVICE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    intc_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_IRQ-1:0] in_service;
    logic [NUM_IRQ-1:0] ack_mask;
    logic               ack_signal;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;

    intc_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .requests (irq_requests),
        .mask     (in_service),
        .valid    (win_valid),
        .id       (win_id)
    );

    // One-hot of the IRQ being acknowledged this cycle
    always_comb begin
        ack_mask = '0;
        if (state == ACK) begin
            ack_mask[irq_id] = 1'b1;
        end
    end

    // Arbitration FSM, service counter, in-service mask and registered outputs.
    // irq_out is still high during the ACK-state cycle, so the CPU sees exactly
    // SERVICE_CYCLES high cycles, then one low cycle carrying the ack pulse.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            in_service <= '0;
            irq_out    <= 1'b0;
            irq_id     <= '0;
            ack_signal <= 1'b0;
        end else begin
            // A dropped request always clears its mask bit, even in the ack cycle
            in_service <= (in_service | ack_mask) & irq_requests;
            ack_signal <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        irq_id  <= win_id;
                        irq_out <= 1'b1;
                        cnt     <= CNT_LOAD;
                        state   <= (SERVICE_CYCLES == 1) ? ACK : SERVICE;
                    end else begin
                        irq_out <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (!irq_requests[irq_id]) begin
                        irq_out <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end
                        if (cnt <= CNT_ONE) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    ack_signal <= 1'b1;
                    irq_out    <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    irq_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef INTC_ACK_PORT_EN
    // irq_id is held while irq_out is low, so it still names the acked IRQ
    assign irq_ack    = ack_signal;
    assign irq_ack_id = irq_id;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic       clk;
    logic       rstn;
    logic [7:0] irq_requests;
    logic       irq_out;
    logic [2:0] irq_id;
`ifdef INTC_ACK_PORT_EN
    logic       irq_ack;
    logic [2:0] irq_ack_id;
`endif

    int n_cmp;
    int n_bad;
    int ack_cnt;
    int ack_base;

    interrupt_controller dut (
        .clk          (clk),
        .rstn         (rstn),
        .irq_requests (irq_requests),
        .irq_out      (irq_out),
        .irq_id       (irq_id)
`ifdef INTC_ACK_PORT_EN
        ,
        .irq_ack      (irq_ack),
        .irq_ack_id   (irq_ack_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.ack_signal === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, then follow it through its service window to the ack
    task automatic service_one(input logic [2:0] exp_id);
        int waited;
        waited = 0;
        while (irq_out !== 1'b1 && waited < 3) begin
            tick();
            waited++;
        end
        check("grant_seen", {31'd0, irq_out}, 32'd1);
        check("grant_id", {29'd0, irq_id}, {29'd0, exp_id});
        for (int k = 1; k < 4; k++) begin
            tick();
            check("svc_out", {31'd0, irq_out}, 32'd1);
            check("svc_noack", {31'd0, dut.ack_signal}, 32'd0);
        end
        tick();
        check("ack_out_low", {31'd0, irq_out}, 32'd0);
        check("ack_pulse", {31'd0, dut.ack_signal}, 32'd1);
        check("ack_id", {29'd0, irq_id}, {29'd0, exp_id});
    endtask

    task automatic clear_and_settle();
        irq_requests = 8'h00;
        tick();
        tick();
        check("clr_out", {31'd0, irq_out}, 32'd0);
        check("clr_mask", {24'd0, dut.in_service}, 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        ack_cnt      = 0;
        rstn         = 1'b1;
        irq_requests = 8'h00;
        tick();
        tick();
        check("rst_out", {31'd0, irq_out}, 32'd0);
        check("rst_id", {29'd0, irq_id}, 32'd0);
        check("rst_ack", {31'd0, dut.ack_signal}, 32'd0);
        rstn = 1'b0;

        // idle: nothing requested
        tick();
        tick();
        check("idle_out", {31'd0, irq_out}, 32'd0);
        check("idle_acks", ack_cnt, 0);

        // single highest-priority request held past its ack
        irq_requests = 8'h01;
        service_one(3'd0);
        check("mask_set", {24'd0, dut.in_service}, 32'h01);
        tick();
        check("held_ack_done", {31'd0, dut.ack_signal}, 32'd0);
        check("held_out", {31'd0, irq_out}, 32'd0);
        tick();
        tick();
        check("held_masked", {31'd0, irq_out}, 32'd0);
        check("one_ack", ack_cnt, 1);
        clear_and_settle();

        // lowest priority alone
        irq_requests = 8'h80;
        service_one(3'd7);
        clear_and_settle();

        // abort: request drops mid-service, no ack
        ack_base     = ack_cnt;
        irq_requests = 8'h80;
        tick();
        check("abort_grant", {31'd0, irq_out}, 32'd1);
        tick();
        irq_requests = 8'h00;
        tick();
        check("abort_out", {31'd0, irq_out}, 32'd0);
        tick();
        tick();
        check("abort_noack", ack_cnt - ack_base, 0);

        // two requests held: 0 then 7, one idle cycle between
        irq_requests = 8'h81;
        service_one(3'd0);
        service_one(3'd7);
        tick();
        tick();
        check("pair_done", {31'd0, irq_out}, 32'd0);
        clear_and_settle();

        // 1 beats 4
        irq_requests = 8'h12;
        service_one(3'd1);
        service_one(3'd4);
        clear_and_settle();

        // all eight in priority order
        ack_base     = ack_cnt;
        irq_requests = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            service_one(3'(i));
        end
        tick();
        check("all_done", {31'd0, irq_out}, 32'd0);
        check("all_mask", {24'd0, dut.in_service}, 32'hFF);
        check("eight_acks", ack_cnt - ack_base, 8);
        clear_and_settle();

        // reset asserted mid-service
        ack_base     = ack_cnt;
        irq_requests = 8'h04;
        tick();
        check("pre_rst_grant", {31'd0, irq_out}, 32'd1);
        check("pre_rst_id", {29'd0, irq_id}, 32'd2);
        tick();
        rstn = 1'b1;
        #1;
        check("mid_rst_out", {31'd0, irq_out}, 32'd0);
        check("mid_rst_id", {29'd0, irq_id}, 32'd0);
        check("mid_rst_ack", {31'd0, dut.ack_signal}, 32'd0);
        tick();
        tick();
        tick();
        check("mid_rst_noack", ack_cnt - ack_base, 0);
        rstn = 1'b0;
        service_one(3'd2);
        clear_and_settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
